// File: rtl/jk_excitation_counter.sv
// jk_excitation_counter: up/down/load counter built from JK flip-flops driven by excitation logic
module jk_excitation_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] nQ,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             tc,
  output logic             wrap
);
  logic [WIDTH-1:0] n;
  always_comb begin
    n  = rst ? '0 : load ? d : en ? (up ? Q + 1'b1 : Q - 1'b1) : Q;
    j  = n & ~Q;
    k  = ~n & Q;
    tc = en & ~load & ~rst & (up ? &Q : ~|Q);
  end
  assign nQ = ~Q;
  always_ff @(posedge clk) begin
    Q    <= rst ? '0 : (j & ~Q) | (~k & Q);
    wrap <= rst ? 1'b0 : tc;
  end
endmodule
